// File: rtl/mem_access_pkg.sv
// Shared definitions for the mem_access stage: FSM state encoding and
// byte-enable patterns used to classify and replicate store data.
package mem_access_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [3:0] BE_B0      = 4'b0001;
    localparam logic [3:0] BE_B1      = 4'b0010;
    localparam logic [3:0] BE_B2      = 4'b0100;
    localparam logic [3:0] BE_B3      = 4'b1000;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_ALL     = 4'b1111;

endpackage

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-memory request per load/store,
// stalls upstream until ack or timeout, and owns the mem/wb pipeline register.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] alu_data_mem,
    input  logic                  reg_d_we_mem,
    input  logic [ADDR_WIDTH-1:0] reg_d_addr_mem,
    input  logic                  reg_d_data_sel_mem,
    input  logic [DATA_WIDTH-1:0] reg_t_data_mem,
    input  logic [3:0]            mem_we_mem,
    output logic                  stall,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  reg_d_we_wb,
    output logic [ADDR_WIDTH-1:0] reg_d_addr_wb,
    output logic [DATA_WIDTH-1:0] reg_d_data_wb,
    output logic                  bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter holds (BUSY cycles elapsed - 1), so the limit is TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                  state;
    logic [CNT_W-1:0]        busy_cnt;
    logic                    store;
    logic                    load;
    logic                    access;
    logic                    at_limit;

    logic                    cap_we;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic [DATA_WIDTH-1:0]   cap_alu;
    logic                    cap_load;

    function automatic logic [31:0] replicate_wdata(input logic [3:0] be,
                                                     input logic [31:0] t);
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: return {4{t[7:0]}};
            BE_LO_HALF, BE_HI_HALF:     return {2{t[15:0]}};
            default:                    return t;
        endcase
    endfunction

    assign store    = |mem_we_mem;
    assign load     = reg_d_data_sel_mem & ~store;
    assign access   = store | load;
    assign at_limit = (busy_cnt == CNT_LAST);

    // Stall drops in the completing BUSY cycle (ack or timeout) so upstream advances on that edge.
    assign stall = (state == ST_IDLE) ? access : ~(dmem_ack | at_limit);

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && access) begin
            cap_we   <= reg_d_we_mem;
            cap_addr <= reg_d_addr_mem;
            cap_alu  <= alu_data_mem;
            cap_load <= load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            busy_cnt      <= '0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_be       <= '0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            reg_d_we_wb   <= 1'b0;
            reg_d_addr_wb <= '0;
            reg_d_data_wb <= '0;
            bus_err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        dmem_req    <= 1'b1;
                        dmem_we     <= store;
                        dmem_be     <= store ? mem_we_mem : BE_ALL;
                        dmem_addr   <= {alu_data_mem[DATA_WIDTH-1:2], 2'b00};
                        dmem_wdata  <= replicate_wdata(store ? mem_we_mem : BE_ALL,
                                                       reg_t_data_mem);
                        busy_cnt    <= '0;
                        reg_d_we_wb <= 1'b0;
                        state       <= ST_BUSY;
                    end else begin
                        reg_d_we_wb   <= reg_d_we_mem;
                        reg_d_addr_wb <= reg_d_addr_mem;
                        reg_d_data_wb <= alu_data_mem;
                    end
                end
                ST_BUSY: begin
                    if (dmem_ack) begin
                        dmem_req      <= 1'b0;
                        reg_d_we_wb   <= cap_we;
                        reg_d_addr_wb <= cap_addr;
                        reg_d_data_wb <= cap_load ? dmem_rdata : cap_alu;
                        state         <= ST_IDLE;
                    end else if (at_limit) begin
                        dmem_req    <= 1'b0;
                        bus_err     <= 1'b1;
                        reg_d_we_wb <= 1'b0;
                        state       <= ST_IDLE;
                    end else begin
                        busy_cnt    <= busy_cnt + CNT_W'(1);
                        reg_d_we_wb <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 5, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, 32, data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT, 255, maximum BUSY cycles before a bus error.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port alu_data_mem  in  DATA_WIDTH  effective address, or ALU result for writeback.
REQ-007 SHALL have port reg_d_we_mem  in  1  destination register write enable.
REQ-008 SHALL have port reg_d_addr_mem  in  ADDR_WIDTH  destination register.
REQ-009 SHALL have port reg_d_data_sel_mem  in  1  1 = load: writeback data comes from memory.
REQ-010 SHALL have port reg_t_data_mem  in  DATA_WIDTH  store data.
REQ-011 SHALL have port mem_we_mem  in  4  lane-aligned byte write enables; nonzero = store.
REQ-012 SHALL have port stall  out  1  holds the upstream ex/mem register.
REQ-013 SHALL have port dmem_req  out  1  data-memory request.
REQ-014 SHALL have port dmem_we  out  1  1 = write.
REQ-015 SHALL have port dmem_be  out  4  byte enables.
REQ-016 SHALL have port dmem_addr  out  DATA_WIDTH  word-aligned address ({addr[31:2],2'b00}).
REQ-017 SHALL have port dmem_wdata  out  DATA_WIDTH  write data.
REQ-018 SHALL have port dmem_ack  in  1  request completes this cycle.
REQ-019 SHALL have port dmem_rdata  in  DATA_WIDTH  read data, valid when dmem_ack=1.
REQ-020 SHALL have ports reg_d_we_wb (1), reg_d_addr_wb (ADDR_WIDTH) and reg_d_data_wb (DATA_WIDTH), all outputs: mem/wb pipeline register.
REQ-021 SHALL have port bus_err  out  1  sticky timeout flag.

Function
REQ-022 SHALL classify the incoming operation:
- store = |mem_we_mem.
- load = reg_d_data_sel_mem & ~store; store takes precedence.
- access = store | load.
REQ-023 SHALL implement a two-state FSM, IDLE and BUSY.
REQ-024 SHALL, in IDLE with access=1:
- register the request: address, be = mem_we_mem for a store, 4'hF for a load, we = store, write data.
- assert stall combinationally.
- transition to BUSY.
REQ-025 SHALL, in IDLE with access=0, write the wb registers on the next edge with alu_data_mem (1-cycle latency) and keep stall=0.
REQ-026 SHALL, in BUSY, drive dmem_req=1 and hold all dmem_* outputs stable until completion; stall=1 unless completing this cycle.
REQ-027 SHALL complete on dmem_ack in BUSY:
- stall=0 in the completing cycle.
- on the next edge, write the wb registers: reg_d_data_wb = dmem_rdata for a load, captured alu data for a store.
- return to IDLE.
REQ-028 SHALL replicate write data by enable pattern:
- single byte: {4{t[7:0]}}.
- 4'b0011 or 4'b1100: {2{t[15:0]}}.
- otherwise: t.
REQ-029 SHALL drive reg_d_we_wb=0 (bubble) on every edge while in BUSY without completion.
REQ-030 SHALL count BUSY cycles with a counter cleared on entering BUSY; when the count reaches TIMEOUT without dmem_ack:
- drop dmem_req.
- set bus_err.
- complete with reg_d_we_wb=0.
- return to IDLE.
REQ-031 SHALL give dmem_ack priority over timeout when both occur in the same cycle.
REQ-032 SHALL ignore dmem_ack in IDLE.
REQ-033 SHALL keep bus_err set until reset.

Reset
REQ-034 SHALL on rst_n=0 asynchronously clear:
- state to IDLE and the counter.
- dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata.
- all wb outputs and bus_err.
REQ-035 SHALL abandon an in-flight request on reset mid-BUSY; dmem_req falls without waiting for dmem_ack.

Structure
REQ-036 SHALL place the FSM state encoding and the byte-enable constants in the shared defines header.
REQ-037 SHALL be a single module with no sub-modules.

Verification
REQ-038 SHALL verify ALU pass-through: alu=0x1234, we=1, addr=5, no access -> next cycle wb=(1, 5, 0x1234), stall never set.
REQ-039 SHALL verify a load: addr 0x103, ack after 3 cycles with rdata=0xDEADBEEF:
- dmem_addr=0x100, be=4'hF.
- stall high for 4 cycles.
- wb data=0xDEADBEEF.
REQ-040 SHALL verify a byte store: mem_we=4'b0100, t=0x000000AB -> wdata=0xABABABAB, we=1, be=4'b0100, wb data=alu value.
REQ-041 SHALL verify timeout: TIMEOUT=4, no ack -> req drops after 4 BUSY cycles, bus_err=1, reg_d_we_wb=0, and the next op proceeds.
REQ-042 SHALL verify reset mid-operation: rst_n low during BUSY -> dmem_req=0, all outputs 0 immediately, then IDLE after release.
REQ-043 SHALL verify ack-and-timeout coincidence: ack on the timeout cycle -> normal completion, bus_err stays 0.
